// File: rtl/mct_pkg.sv
// mct_pkg: shared types and helpers for the multi-channel RAM bus controller.
//   - access size encodings (SZ_B / SZ_H / SZ_W, code 3 behaves as a word)
//   - controller state enum
//   - arbitration mode selectors
//   - nbytes(): bytes moved for a given size code
package mct_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        TAIL = 2'd2,
        DONE = 2'd3
    } state_e;

    // Size code 3 is reserved and moves a full word.
    function automatic logic [2:0] nbytes(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mct_rr_arb.sv
// mct_rr_arb: combinational channel arbiter.
//   eligible  in  N_CH   channels allowed to win this cycle
//   ptr       in  IDX_W  last granted channel (round-robin mode only)
//   grant     out N_CH   one-hot winner, zero when nothing is eligible
//   grant_idx out IDX_W  binary index of the winner
//   any       out 1      at least one channel eligible
// ARB_MODE 0: highest eligible index wins. ARB_MODE 1: first eligible
// channel strictly after ptr, searching cyclically.
module mct_rr_arb
    import mct_pkg::*;
#(
    parameter int N_CH     = 2,
    parameter int ARB_MODE = ARB_FIXED,
    parameter int IDX_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic [N_CH-1:0]  eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_CH-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    always_comb begin
        int j;
        j         = 0;
        grant     = '0;
        grant_idx = '0;
        any       = |eligible;
        if (ARB_MODE == ARB_FIXED) begin
            // Ascending scan: the last hit is the highest index.
            for (int i = 0; i < N_CH; i++) begin
                if (eligible[i]) grant_idx = IDX_W'(i);
            end
        end else begin
            // Descending distance from ptr: the last hit is the nearest
            // channel after ptr; distance N_CH revisits ptr itself.
            for (int k = N_CH; k >= 1; k--) begin
                j = (int'(ptr) + k) % N_CH;
                if (eligible[j]) grant_idx = IDX_W'(j);
            end
        end
        if (any) grant[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/mct_multi.sv
// mct_multi: arbitrates N_CH requesters onto one byte-wide external RAM bus.
//   clk, rst            clock, asynchronous active-high reset
//   ch_req/ch_wr        per-channel request (held until ch_ok) and direction
//   ch_size             per-channel size code (byte/half/word)
//   ch_addr/ch_wdata    per-channel byte address and little-endian write data
//   ch_cancel           aborts a pending or in-flight read of that channel
//   ch_ok               one-cycle completion pulse of the served channel
//   ch_rdata            zero-extended read data, held until the next read completes
//   busy                controller not idle
//   rom_rn              RAM read byte, one cycle after its address
//   rom_a/rom_wn/rom_wr RAM address, write byte and write enable
// Every output is a flop; each bus value is computed one cycle ahead so that
// byte k appears on the pins in transfer cycle C(k+1).
module mct_multi
    import mct_pkg::*;
#(
    parameter int N_CH     = 2,
    parameter int ADDR_W   = 32,
    parameter int ARB_MODE = ARB_FIXED
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        ch_req,
    input  logic [N_CH-1:0]        ch_wr,
    input  logic [N_CH-1:0][1:0]   ch_size,
    input  logic [N_CH-1:0][31:0]  ch_addr,
    input  logic [N_CH-1:0][31:0]  ch_wdata,
    input  logic [N_CH-1:0]        ch_cancel,
    output logic [N_CH-1:0]        ch_ok,
    output logic [31:0]            ch_rdata,
    output logic                   busy,
    input  logic [7:0]             rom_rn,
    output logic [7:0]             rom_wn,
    output logic [ADDR_W-1:0]      rom_a,
    output logic                   rom_wr
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    gnt_q, gnt_d, ptr_q, ptr_d;
    logic                wr_q, wr_d;
    logic [1:0]          last_q, last_d, cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d, rdata_q, rdata_d;
    logic [ADDR_W-1:0]   rom_a_q, rom_a_d;
    logic [7:0]          rom_wn_q, rom_wn_d;
    logic                rom_wr_q, rom_wr_d;
    logic [N_CH-1:0]     ch_ok_q, ch_ok_d;
    logic [31:0]         ch_rdata_q, ch_rdata_d;
    logic                busy_q, busy_d;

    logic [N_CH-1:0]     eligible, arb_grant;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_any;

    assign eligible = ch_req & ~ch_cancel;

    mct_rr_arb #(.N_CH(N_CH), .ARB_MODE(ARB_MODE), .IDX_W(IDX_W)) u_arb (
        .eligible  (eligible),
        .ptr       (ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ptr_d      = ptr_q;
        wr_d       = wr_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        rom_a_d    = rom_a_q;
        rom_wn_d   = rom_wn_q;
        rom_wr_d   = rom_wr_q;
        ch_ok_d    = '0;
        ch_rdata_d = ch_rdata_q;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    gnt_d    = arb_idx;
                    ptr_d    = arb_idx;
                    wr_d     = ch_wr[arb_idx];
                    last_d   = 2'(nbytes(ch_size[arb_idx]) - 3'd1);
                    cnt_d    = 2'd0;
                    addr_d   = ch_addr[arb_idx][ADDR_W-1:0];
                    wdata_d  = ch_wdata[arb_idx];
                    rdata_d  = '0;
                    // Byte 0 goes straight onto the bus in C1.
                    rom_a_d  = ch_addr[arb_idx][ADDR_W-1:0];
                    rom_wn_d = ch_wdata[arb_idx][7:0];
                    rom_wr_d = ch_wr[arb_idx];
                    state_d  = XFER;
                end
            end
            XFER: begin
                // rom_rn now carries the byte addressed in the previous cycle.
                if (!wr_q && cnt_q != 2'd0)
                    rdata_d[{cnt_q - 2'd1, 3'b000} +: 8] = rom_rn;
                if (!wr_q && ch_cancel[gnt_q]) begin
                    state_d = IDLE;
                end else if (cnt_q == last_q) begin
                    rom_wr_d = 1'b0;
                    if (wr_q) begin
                        ch_ok_d[gnt_q] = 1'b1;
                        state_d        = DONE;
                    end else begin
                        state_d = TAIL;
                    end
                end else begin
                    cnt_d    = cnt_q + 2'd1;
                    rom_a_d  = addr_q + ADDR_W'(cnt_d);
                    rom_wn_d = wdata_q[{cnt_d, 3'b000} +: 8];
                end
            end
            TAIL: begin
                rdata_d[{last_q, 3'b000} +: 8] = rom_rn;
                if (ch_cancel[gnt_q]) begin
                    state_d = IDLE;
                end else begin
                    ch_ok_d[gnt_q] = 1'b1;
                    ch_rdata_d     = rdata_d;
                    state_d        = DONE;
                end
            end
            default: state_d = IDLE;   // DONE: requester drops req here
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            ptr_q      <= IDX_W'(N_CH - 1);
            wr_q       <= 1'b0;
            last_q     <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rom_a_q    <= '0;
            rom_wn_q   <= '0;
            rom_wr_q   <= 1'b0;
            ch_ok_q    <= '0;
            ch_rdata_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ptr_q      <= ptr_d;
            wr_q       <= wr_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            rom_a_q    <= rom_a_d;
            rom_wn_q   <= rom_wn_d;
            rom_wr_q   <= rom_wr_d;
            ch_ok_q    <= ch_ok_d;
            ch_rdata_q <= ch_rdata_d;
            busy_q     <= busy_d;
        end
    end

    assign rom_a    = rom_a_q;
    assign rom_wn   = rom_wn_q;
    assign rom_wr   = rom_wr_q;
    assign ch_ok    = ch_ok_q;
    assign ch_rdata = ch_rdata_q;
    assign busy     = busy_q;

endmodule
